// File: rtl/variable_pkg.sv
// Shared game-flow definitions for the VGA overlay pipeline.
//   game_state_t      : session state of the result sequencer
//   DEF_BLINK_FRAMES  : default frames per overlay on/off phase
//   DEF_HOLD_FRAMES   : default frames the result screen is held (5 s at 60 Hz)
package variable_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        WIN   = 2'd2,
        LOOSE = 2'd3
    } game_state_t;

    localparam int DEF_BLINK_FRAMES = 30;
    localparam int DEF_HOLD_FRAMES  = 300;

endpackage

// File: rtl/game_result_ctrl_rise_edge.sv
// Registered rising-edge detector.
//   clk    : clock
//   rst    : asynchronous active-high reset (clears the delay register)
//   i_sig  : level input, already synchronous to clk
//   o_rise : high in the cycle where i_sig is 1 and was 0 on the previous edge
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/game_result_ctrl.sv
// Game-flow sequencer for the win/loose overlay stage.
// Tracks IDLE -> PLAY -> WIN/LOOSE -> IDLE, blinks the matching overlay in
// units of video frames and pulses restart when the result screen ends.
//   clk60MHz    : system clock
//   rst         : asynchronous active-high reset
//   vsync       : frame sync; its rising edge is the frame tick
//   start       : start key level (synchronised)
//   player_hp   : player health, 0 = player dead
//   enemy_hp    : opponent health, 0 = opponent dead
//   win         : green overlay enable (blinks during WIN)
//   loose       : red overlay enable (blinks during LOOSE)
//   game_active : high only in PLAY
//   restart     : one-cycle pulse when leaving the result screen
module game_result_ctrl
    import variable_pkg::*;
#(
    parameter int HP_W         = 4,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES,
    parameter int CNT_W        = 9
) (
    input  logic            clk60MHz,
    input  logic            rst,
    input  logic            vsync,
    input  logic            start,
    input  logic [HP_W-1:0] player_hp,
    input  logic [HP_W-1:0] enemy_hp,
    output logic            win,
    output logic            loose,
    output logic            game_active,
    output logic            restart
);

    if (HOLD_FRAMES > (2**CNT_W) - 1 || BLINK_FRAMES < 1) begin : g_param_check
        $error("game_result_ctrl: HOLD_FRAMES must fit in CNT_W and BLINK_FRAMES must be >= 1");
    end

    logic w_frame_tick;
    logic w_start_rise;

    rise_edge u_vsync_edge (
        .clk    (clk60MHz),
        .rst    (rst),
        .i_sig  (vsync),
        .o_rise (w_frame_tick)
    );

    rise_edge u_start_edge (
        .clk    (clk60MHz),
        .rst    (rst),
        .i_sig  (start),
        .o_rise (w_start_rise)
    );

    game_state_t        r_state;
    logic [CNT_W-1:0]   r_frame_cnt;
    // Counts ticks within the current blink phase. It restarts together with
    // r_frame_cnt on result entry, so its wrap coincides with
    // (frame_cnt+1) being a multiple of BLINK_FRAMES without needing a modulo.
    logic [CNT_W-1:0]   r_blink_cnt;
    logic               r_blink_phase;
    logic               r_win;
    logic               r_loose;
    logic               r_game_active;
    logic               r_restart;

    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_blink_wrap;
    logic               w_phase_next;
    logic               w_hold_done;
    logic               w_skip;
    logic               w_exit;

    assign w_cnt_inc    = r_frame_cnt + CNT_W'(1);
    assign w_blink_wrap = (r_blink_cnt == CNT_W'(BLINK_FRAMES - 1));
    assign w_phase_next = r_blink_phase ^ (w_frame_tick & w_blink_wrap);
    assign w_hold_done  = w_frame_tick && (w_cnt_inc == CNT_W'(HOLD_FRAMES));
    // Early skip only after the first blink period, so a key still held from
    // play (or bounced right at the death) cannot skip the result screen.
    assign w_skip       = w_start_rise && (r_frame_cnt >= CNT_W'(BLINK_FRAMES));
    assign w_exit       = w_hold_done || w_skip;

    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_frame_cnt   <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_win         <= 1'b0;
            r_loose       <= 1'b0;
            r_game_active <= 1'b0;
            r_restart     <= 1'b0;
        end else begin
            r_restart <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_win         <= 1'b0;
                    r_loose       <= 1'b0;
                    r_game_active <= 1'b0;
                    if (w_start_rise) begin
                        r_state       <= PLAY;
                        r_game_active <= 1'b1;
                    end
                end

                PLAY: begin
                    // Player death wins the tie: a double KO counts as a loss.
                    if (player_hp == '0) begin
                        r_state       <= LOOSE;
                        r_game_active <= 1'b0;
                        r_frame_cnt   <= '0;
                        r_blink_cnt   <= '0;
                        r_blink_phase <= 1'b1;
                        r_loose       <= 1'b1;
                    end else if (enemy_hp == '0) begin
                        r_state       <= WIN;
                        r_game_active <= 1'b0;
                        r_frame_cnt   <= '0;
                        r_blink_cnt   <= '0;
                        r_blink_phase <= 1'b1;
                        r_win         <= 1'b1;
                    end else begin
                        r_game_active <= 1'b1;
                    end
                end

                WIN, LOOSE: begin
                    r_game_active <= 1'b0;
                    if (w_exit) begin
                        r_state       <= IDLE;
                        r_restart     <= 1'b1;
                        r_frame_cnt   <= '0;
                        r_blink_cnt   <= '0;
                        r_blink_phase <= 1'b0;
                        r_win         <= 1'b0;
                        r_loose       <= 1'b0;
                    end else begin
                        if (w_frame_tick) begin
                            r_frame_cnt <= w_cnt_inc;
                            r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + CNT_W'(1);
                        end
                        r_blink_phase <= w_phase_next;
                        r_win         <= (r_state == WIN)   ? w_phase_next : 1'b0;
                        r_loose       <= (r_state == LOOSE) ? w_phase_next : 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign win         = r_win;
    assign loose       = r_loose;
    assign game_active = r_game_active;
    assign restart     = r_restart;

endmodule

// File: tb/tb_game_result_ctrl.sv
// Self-checking bench for game_result_ctrl with BLINK_FRAMES=2, HOLD_FRAMES=6.
// The reference model tracks the session as a mode plus elapsed frame count
// and derives overlay levels from frames/BLINK arithmetic.
module tb_game_result_ctrl;

    localparam int HP_W      = 4;
    localparam int BLINK     = 2;
    localparam int HOLD      = 6;
    localparam int CNT_W     = 9;
    localparam int FRAME_CYC = 7;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_WIN   = 2;
    localparam int M_LOOSE = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            vsync;
    logic            start;
    logic [HP_W-1:0] player_hp;
    logic [HP_W-1:0] enemy_hp;
    logic            win;
    logic            loose;
    logic            game_active;
    logic            restart;

    game_result_ctrl #(
        .HP_W         (HP_W),
        .BLINK_FRAMES (BLINK),
        .HOLD_FRAMES  (HOLD),
        .CNT_W        (CNT_W)
    ) dut (
        .clk60MHz    (clk),
        .rst         (rst),
        .vsync       (vsync),
        .start       (start),
        .player_hp   (player_hp),
        .enemy_hp    (enemy_hp),
        .win         (win),
        .loose       (loose),
        .game_active (game_active),
        .restart     (restart)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_mode   = M_IDLE;
    int m_frames = 0;
    int m_restart = 0;
    int m_pv = 0;
    int m_ps = 0;
    int vs_cnt = 0;
    int n_restart_seen = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_frames = 0; m_restart = 0; m_pv = 0; m_ps = 0;
    endtask

    // Next-state of the model from the inputs present at the coming edge.
    task automatic model_update();
        int tick, rise;
        tick = (vsync && !m_pv) ? 1 : 0;
        rise = (start && !m_ps) ? 1 : 0;
        m_restart = 0;
        case (m_mode)
            M_IDLE: if (rise) m_mode = M_PLAY;
            M_PLAY: begin
                if (player_hp == 0)     begin m_mode = M_LOOSE; m_frames = 0; end
                else if (enemy_hp == 0) begin m_mode = M_WIN;   m_frames = 0; end
            end
            default: begin
                if ((tick && m_frames + 1 == HOLD) || (rise && m_frames >= BLINK)) begin
                    m_mode = M_IDLE; m_restart = 1; m_frames = 0;
                end else if (tick) begin
                    m_frames++;
                end
            end
        endcase
        m_pv = vsync;
        m_ps = start;
    endtask

    function automatic int exp_overlay(input int mode);
        return (m_mode == mode && ((m_frames / BLINK) % 2 == 0)) ? 1 : 0;
    endfunction

    task automatic compare_outputs(input string where);
        check({where, ":win"},         win,         exp_overlay(M_WIN));
        check({where, ":loose"},       loose,       exp_overlay(M_LOOSE));
        check({where, ":game_active"}, game_active, (m_mode == M_PLAY) ? 1 : 0);
        check({where, ":restart"},     restart,     m_restart);
        check({where, ":exclusive"},   int'(win & loose), 0);
        if (restart) n_restart_seen++;
    endtask

    // One clock: vsync pattern advances, model steps, outputs compared after the edge.
    task automatic step(input string where);
        vsync = ((vs_cnt % FRAME_CYC) < 2);
        vs_cnt++;
        if (rst) model_reset();
        else     model_update();
        @(posedge clk);
        #1;
        compare_outputs(where);
    endtask

    task automatic do_async_reset(input string where);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check({where, ":rst_win"},    win, 0);
        check({where, ":rst_loose"},  loose, 0);
        check({where, ":rst_active"}, game_active, 0);
        check({where, ":rst_restart"}, restart, 0);
        check({where, ":rst_cnt"},    int'(dut.r_frame_cnt), 0);
        check({where, ":rst_state"},  int'(dut.r_state), 0);
        step(where);
        #2 rst = 1'b0;
    endtask

    task automatic run_until_mode(input string where, input int mode, input int maxc);
        int c = 0;
        while (m_mode != mode && c < maxc) begin
            step(where);
            c++;
        end
        if (m_mode != mode) check({where, ":timeout"}, m_mode, mode);
    endtask

    task automatic run_until_frames(input string where, input int fr, input int maxc);
        int c = 0;
        while (m_frames < fr && c < maxc) begin
            step(where);
            c++;
        end
        if (m_frames < fr) check({where, ":timeout"}, m_frames, fr);
    endtask

    task automatic pulse_start(input string where);
        start = 1'b1;
        step(where);
        start = 1'b0;
    endtask

    initial begin
        int r0;
        rst = 1'b1; vsync = 1'b0; start = 1'b0;
        player_hp = 4'd5; enemy_hp = 4'd5;
        #3;
        check("init:win", win, 0);
        check("init:loose", loose, 0);
        check("init:active", game_active, 0);
        check("init:restart", restart, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // idle stays idle without start
        repeat (3) step("idle");

        // win path
        pulse_start("win_start");
        repeat (3) step("play");
        enemy_hp = 4'd0;
        step("win_enter");
        check("win_first", win, 1);
        enemy_hp = 4'd5;
        r0 = n_restart_seen;
        run_until_mode("win_run", M_IDLE, 200);
        check("win_restart_count", n_restart_seen - r0, 1);
        repeat (2) step("win_after");

        // simultaneous death
        pulse_start("dk_start");
        step("dk_play");
        player_hp = 4'd0; enemy_hp = 4'd0;
        step("dk_enter");
        check("dk_loose", loose, 1);
        check("dk_win", win, 0);
        player_hp = 4'd7; enemy_hp = 4'd7;

        // early skip in LOOSE (continues from double KO)
        run_until_frames("skip_wait1", 1, 100);
        pulse_start("skip_ignored");
        check("skip_ignored_active", loose | win, 1);
        run_until_frames("skip_wait3", 3, 100);
        pulse_start("skip_taken");
        check("skip_taken_restart", restart, 1);
        step("skip_after");

        // held key from IDLE through PLAY into WIN
        start = 1'b1;
        step("held_enter");
        step("held_play");
        enemy_hp = 4'd0;
        step("held_win");
        enemy_hp = 4'd7;
        r0 = n_restart_seen;
        run_until_mode("held_run", M_IDLE, 200);
        check("held_restart_count", n_restart_seen - r0, 1);
        repeat (3) step("held_idle");
        start = 1'b0;
        step("held_release");

        // reset in the middle of a WIN screen
        pulse_start("mr_start");
        enemy_hp = 4'd0;
        step("mr_win");
        enemy_hp = 4'd7;
        run_until_frames("mr_wait3", 3, 100);
        r0 = n_restart_seen;
        do_async_reset("mr_reset");
        repeat (60) step("mr_after");
        check("mr_no_restart", n_restart_seen - r0, 0);

        // randomized sessions
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) start = ~start;
            player_hp = ($urandom_range(0, 40) == 0) ? 4'd0 : HP_W'($urandom_range(1, 15));
            enemy_hp  = ($urandom_range(0, 40) == 0) ? 4'd0 : HP_W'($urandom_range(1, 15));
            if ($urandom_range(0, 599) == 0) do_async_reset("rnd_reset");
            else step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
